aes_inv_cipher_iter: RTL and testbench
======================================

Name: aes_inv_cipher_iter

Overview:
- Iterative, parametrised AES inverse-cipher core.
- Takes one 128-bit ciphertext block per transaction and applies the initial AddRoundKey, then NR inverse rounds using one shared round datapath, one round per clock.
- Round keys come from an external, pre-expanded key store, addressed by key_idx.
- Sits between the block input FIFO and the output FIFO. Generalises the single decrypt round to a full AES-128/192/256 decrypt with valid/ready handshakes and abort.

Parameters:
- NR, 10, number of rounds; legal values 10, 12, 14. Elaboration error on any other value.
- KIW, 4, width of key_idx; must satisfy 2^KIW > NR.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  ciphertext block valid
- in_ready  output  1  core can accept a block
- data_in  input  128  ciphertext block; byte 0 in bits [127:120]
- key_idx  output  KIW  round-key index requested this cycle
- key_in  input  128  round key for key_idx; combinational lookup, sampled on the same edge
- abort  input  1  synchronous flush of the current block
- out_valid  output  1  plaintext valid
- out_ready  input  1  downstream accepts plaintext
- data_out  output  128  plaintext block

Behaviour:
- Reset (rst_n low, async): state=IDLE, rcnt=0, state register=0, in_ready=1, out_valid=0, data_out=0, key_idx=NR.
- States: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1, key_idx=NR.
  - On in_valid&&!abort at an edge: st <= data_in ^ key_in, rcnt <= NR-1, go to ROUND.
- ROUND:
  - in_ready=0, key_idx=rcnt.
  - Each edge: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ key_in). The InvMixColumns step is omitted when rcnt==0.
  - rcnt decrements.
  - After the rcnt==0 round, go to DONE.
- DONE:
  - out_valid=1, data_out=st (held stable), key_idx=0.
  - On out_ready at an edge: go to IDLE, out_valid drops.
- Latency: acceptance edge E; out_valid is high after edge E+NR. Throughput is one block per NR+2 cycles at most.
- Handshake rules:
  - data_out must not change while out_valid && !out_ready.
  - in_ready is combinational from state only. It never depends on in_valid.
- abort:
  - In ROUND or DONE: next edge goes to IDLE, out_valid=0, st and rcnt are cleared, and the block is discarded.
  - In IDLE: abort wins over in_valid, so no acceptance occurs.
  - abort and out_ready together in DONE: treated as abort; the block counts as not delivered.
- key_in is don't-care in DONE.
- X on key_in in IDLE without in_valid must not propagate into st.
- Reset mid-operation returns to the reset state immediately. No output is produced for the in-flight block.

Optional Feature:
- Macro AES_DEC_BYPASS_EN.
- When defined:
  - Adds input bypass (1 bit), sampled with the block at acceptance.
  - If bypass=1, the block skips rounds: IDLE -> DONE at the acceptance edge, with st <= data_in (no key XOR).
  - out_valid is high after edge E+1. abort rules are unchanged.
- When undefined: the port is absent and every block is decrypted.

Decomposition:
- Package aes_dec_pkg:
  - AES_BLK_W=128.
  - State enum {IDLE, ROUND, DONE}.
  - Legal NR constants NR_128=10, NR_192=12, NR_256=14.
  - Functions for xtime/gf_mul by 9, 11, 13, 14.
- Sub-module aes_inv_round_comb, purely combinational:
  - Inputs: st_in[127:0], rk[127:0], last (1 bit).
  - Output: st_out = InvShiftRows -> InvSubBytes -> XOR rk -> InvMixColumns unless last.
  - Contains the inverse S-box ROM.
- The top level holds the FSM, rcnt, st and the handshake logic.

Test Plan:
- NR=10, FIPS-197 C.1 keys (000102…0f) from bench key store; data_in=69c4e0d86a7b0430d8cdb78070b4c55a -> data_out=00112233445566778899aabbccddeeff, out_valid exactly 10 cycles after acceptance; key_idx sequence 10,9,…,0.
- NR=14, FIPS-197 C.3 key (000102…1f); data_in=8ea2b7ca516745bfeafc49904b496089 -> data_out=00112233445566778899aabbccddeeff after 14 cycles.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> data_out stable, in_ready=0 throughout; second block is accepted only on the cycle after out_ready=1.
- Abort: assert abort when rcnt=5 -> out_valid never rises for that block, in_ready=1 next cycle; next C.1 block decrypts correctly.
- Async reset: drop rst_n mid-ROUND, between clock edges -> out_valid=0, in_ready=1 immediately; recovery block decrypts correctly; abort+in_valid in IDLE -> no acceptance.
- With AES_DEC_BYPASS_EN, bypass=1, data_in=deadbeef… -> identical data_out one cycle after acceptance.

Source files
------------

// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES inverse cipher.
package aes_dec_pkg;

    localparam int AES_BLK_W = 128;
    localparam int NR_128    = 10;
    localparam int NR_192    = 12;
    localparam int NR_256    = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] b);
        logic [7:0] x2, x8;
        x2 = xtime(b);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] b);
        logic [7:0] x4, x8;
        x4 = xtime(xtime(b));
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/aes_inv_round_comb.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns
// (the column mix is skipped when last is set). Byte 0 sits in bits [127:120].
module aes_inv_round_comb
    import aes_dec_pkg::*;
(
    input  logic [AES_BLK_W-1:0] st_in,
    input  logic [AES_BLK_W-1:0] rk,
    input  logic                 last,
    output logic [AES_BLK_W-1:0] st_out
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    logic [7:0] b_in  [16];
    logic [7:0] b_sr  [16];
    logic [7:0] b_ark [16];
    logic [7:0] b_out [16];

    // Byte index is 4*column + row; InvShiftRows rotates row r right by r columns.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            b_in[i] = st_in[127-8*i -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                b_sr[4*c+r] = b_in[4*((c - r + 4) % 4) + r];
            end
        end
        for (int i = 0; i < 16; i++) begin
            b_ark[i] = INV_SBOX[b_sr[i]] ^ rk[127-8*i -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            b_out[4*c+0] = gf_mul14(b_ark[4*c]) ^ gf_mul11(b_ark[4*c+1]) ^ gf_mul13(b_ark[4*c+2]) ^ gf_mul9(b_ark[4*c+3]);
            b_out[4*c+1] = gf_mul9(b_ark[4*c])  ^ gf_mul14(b_ark[4*c+1]) ^ gf_mul11(b_ark[4*c+2]) ^ gf_mul13(b_ark[4*c+3]);
            b_out[4*c+2] = gf_mul13(b_ark[4*c]) ^ gf_mul9(b_ark[4*c+1])  ^ gf_mul14(b_ark[4*c+2]) ^ gf_mul11(b_ark[4*c+3]);
            b_out[4*c+3] = gf_mul11(b_ark[4*c]) ^ gf_mul13(b_ark[4*c+1]) ^ gf_mul9(b_ark[4*c+2])  ^ gf_mul14(b_ark[4*c+3]);
        end
        for (int i = 0; i < 16; i++) begin
            st_out[127-8*i -: 8] = last ? b_ark[i] : b_out[i];
        end
    end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128/192/256 inverse cipher, one round per clock, external round-key store.
// Optional macro AES_DEC_BYPASS_EN adds a bypass input that forwards the block untouched.
module aes_inv_cipher_iter
    import aes_dec_pkg::*;
#(
    parameter int NR  = 10,
    parameter int KIW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] data_in,
    output logic [KIW-1:0]       key_idx,
    input  logic [AES_BLK_W-1:0] key_in,
    input  logic                 abort,
`ifdef AES_DEC_BYPASS_EN
    input  logic                 bypass,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] data_out
);

    if (!(NR == NR_128 || NR == NR_192 || NR == NR_256)) begin : g_nr_check
        $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
    end
    if ((1 << KIW) <= NR) begin : g_kiw_check
        $error("aes_inv_cipher_iter: KIW too narrow to address NR+1 round keys");
    end

    localparam logic [KIW-1:0] KIDX_INIT  = KIW'(NR);
    localparam logic [KIW-1:0] RCNT_FIRST = KIW'(NR - 1);

    state_e                state_q, state_d;
    logic [KIW-1:0]        rcnt_q, rcnt_d;
    logic [AES_BLK_W-1:0]  st_q, st_d;
    logic [AES_BLK_W-1:0]  round_out;
    logic                  bypass_sel;
    logic                  accept;

`ifdef AES_DEC_BYPASS_EN
    assign bypass_sel = bypass;
`else
    assign bypass_sel = 1'b0;
`endif

    assign accept = (state_q == IDLE) && in_valid && !abort;

    aes_inv_round_comb u_round (
        .st_in  (st_q),
        .rk     (key_in),
        .last   (rcnt_q == '0),
        .st_out (round_out)
    );

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            st_q    <= st_d;
        end
    end

    // NOTE: defaults first so no path through the case leaves a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = bypass_sel ? DONE : ROUND;
            ROUND:   if (abort) state_d = IDLE;
                     else if (rcnt_q == '0) state_d = DONE;
            DONE:    if (abort || out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // key_in is only consumed on accepting or round edges, so an idle X cannot reach st.
    always_comb begin
        st_d   = st_q;
        rcnt_d = rcnt_q;
        unique case (state_q)
            IDLE: if (accept) begin
                st_d   = bypass_sel ? data_in : (data_in ^ key_in);
                rcnt_d = bypass_sel ? '0 : RCNT_FIRST;
            end
            ROUND: if (abort) begin
                st_d   = '0;
                rcnt_d = '0;
            end else begin
                st_d   = round_out;
                rcnt_d = (rcnt_q == '0) ? '0 : rcnt_q - 1'b1;
            end
            DONE: if (abort) begin
                st_d   = '0;
                rcnt_d = '0;
            end
            default: begin
                st_d   = '0;
                rcnt_d = '0;
            end
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        key_idx   = '0;
        unique case (state_q)
            IDLE:    begin
                in_ready = 1'b1;
                key_idx  = KIDX_INIT;
            end
            ROUND:   key_idx = rcnt_q;
            DONE:    out_valid = 1'b1;
            default: key_idx = '0;
        endcase
    end

    assign data_out = st_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: NR=10 and NR=14 instances checked against a forward-AES
// reference and a transaction-level timing model.
`timescale 1ns/1ps
module tb_aes_inv_cipher_iter;

    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [127:0] data_in   [2];
    logic [3:0]   key_idx   [2];
    logic [127:0] key_in    [2];
    logic         abort     [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [127:0] data_out  [2];
    logic [127:0] cur_pt    [2];
    logic [127:0] rk        [2][16];
    logic [7:0]   sb        [256];
`ifdef AES_DEC_BYPASS_EN
    logic         bypass    [2];
`endif

    int n_checks = 0;
    int n_pass   = 0;

    bit           m_busy [2];
    int           m_cnt  [2];
    logic [127:0] m_exp  [2];

    always #5 clk = ~clk;

    assign key_in[0] = rk[0][key_idx[0]];
    assign key_in[1] = rk[1][key_idx[1]];

    aes_inv_cipher_iter #(.NR(10), .KIW(4)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .data_in(data_in[0]), .key_idx(key_idx[0]), .key_in(key_in[0]), .abort(abort[0]),
`ifdef AES_DEC_BYPASS_EN
        .bypass(bypass[0]),
`endif
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .data_out(data_out[0])
    );

    aes_inv_cipher_iter #(.NR(14), .KIW(4)) u_dut14 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .data_in(data_in[1]), .key_idx(key_idx[1]), .key_in(key_in[1]), .abort(abort[1]),
`ifdef AES_DEC_BYPASS_EN
        .bypass(bypass[1]),
`endif
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .data_out(data_out[1])
    );

    function automatic int nr_of(input int d);
        return (d == 0) ? 10 : 14;
    endfunction

    function automatic bit byp(input int d);
`ifdef AES_DEC_BYPASS_EN
        return bypass[d];
`else
        return (d < 0);
`endif
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---- forward AES reference ----
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] w;
        w = {x, x} << n;
        return w[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic expand(input int d, input int nk, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int          nr;
        nr   = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[d][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    function automatic logic [127:0] encrypt(input int d, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] blk;
        blk = pt ^ rk[d][0];
        for (int r = 1; r <= nr_of(d); r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[blk[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) t[4*c+w] = s[4*((c + w) % 4) + w];
            for (int c = 0; c < 4; c++) begin
                if (r == nr_of(d)) begin
                    for (int w = 0; w < 4; w++) s[4*c+w] = t[4*c+w];
                end else begin
                    s[4*c+0] = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
                    s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
                end
            end
            for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = s[i];
            blk ^= rk[d][r];
        end
        return blk;
    endfunction

    // ---- transaction timing model: accepted block appears NR edges later, held until taken ----
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] <= 1'b0;
                m_cnt[d]  <= 0;
                m_exp[d]  <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!m_busy[d]) begin
                    if (in_valid[d] && !abort[d]) begin
                        m_busy[d] <= 1'b1;
                        m_cnt[d]  <= byp(d) ? nr_of(d) : 0;
                        m_exp[d]  <= byp(d) ? data_in[d] : cur_pt[d];
                    end
                end else if (abort[d] || (m_cnt[d] == nr_of(d) && out_ready[d])) begin
                    m_busy[d] <= 1'b0;
                end else if (m_cnt[d] < nr_of(d)) begin
                    m_cnt[d] <= m_cnt[d] + 1;
                end
            end
        end
    end

    initial begin
        int exp_k;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int d = 0; d < 2; d++) begin
                    exp_k = !m_busy[d] ? nr_of(d) : (m_cnt[d] < nr_of(d) ? nr_of(d) - 1 - m_cnt[d] : 0);
                    check($sformatf("in_ready[%0d]", d), in_ready[d], !m_busy[d]);
                    check($sformatf("out_valid[%0d]", d), out_valid[d], m_busy[d] && m_cnt[d] == nr_of(d));
                    check($sformatf("key_idx[%0d]", d), key_idx[d], exp_k);
                    if (m_busy[d] && m_cnt[d] == nr_of(d))
                        check($sformatf("data_out[%0d]", d), data_out[d], m_exp[d]);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---- drivers ----
    task automatic send(input int d, input logic [127:0] ct, input logic [127:0] pt);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!in_ready[d] && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_ready", in_ready[d], 1'b1);
        data_in[d]  = ct;
        cur_pt[d]   = pt;
        in_valid[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_valid(input int d, output int cyc);
        cyc = 0;
        while (!out_valid[d] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("out_valid_seen", out_valid[d], 1'b1);
    endtask

    task automatic release_out(input int d);
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
    endtask

    initial begin
        int          cyc;
        bit          seen;
        logic [127:0] pt2;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; abort[d] = 1'b0; out_ready[d] = 1'b0;
            data_in[d] = '0; cur_pt[d] = '0;
`ifdef AES_DEC_BYPASS_EN
            bypass[d] = 1'b0;
`endif
        end
        build_sbox();
        expand(0, 4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        expand(1, 8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state and model pins against FIPS-197 vectors
        check("reset_data_out", data_out[0], 128'h0);
        check("reset_key_idx", key_idx[0], 4'd10);
        check("reset_in_ready", in_ready[0], 1'b1);
        check("model_c1", encrypt(0, PT), C1_CT);
        check("model_c3", encrypt(1, PT), C3_CT);

        // C.1 on NR=10 and C.3 on NR=14
        send(0, C1_CT, PT);
        wait_valid(0, cyc);
        check("c1_latency", cyc, 10);
        check("c1_data", data_out[0], PT);
        release_out(0);
        send(1, C3_CT, PT);
        wait_valid(1, cyc);
        check("c3_latency", cyc, 14);
        check("c3_data", data_out[1], PT);
        release_out(1);

        // Backpressure with a second block waiting
        send(0, C1_CT, PT);
        wait_valid(0, cyc);
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        data_in[0] = encrypt(0, pt2); cur_pt[0] = pt2; in_valid[0] = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            check("bp_hold", data_out[0], PT);
            check("bp_in_ready", in_ready[0], 1'b0);
        end
        release_out(0);
        check("bp_ready_after", in_ready[0], 1'b1);
        check("bp_valid_drop", out_valid[0], 1'b0);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check("bp_second_accepted", in_ready[0], 1'b0);
        wait_valid(0, cyc);
        check("bp_second_data", data_out[0], pt2);
        release_out(0);

        // Abort at rcnt=5
        send(0, C1_CT, PT);
        cyc = 0;
        while (key_idx[0] != 4'd5 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        abort[0] = 1'b1;
        @(posedge clk); #1;
        abort[0] = 1'b0;
        check("abort_in_ready", in_ready[0], 1'b1);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            seen |= out_valid[0];
        end
        check("abort_no_output", seen, 1'b0);
        send(0, C1_CT, PT);
        wait_valid(0, cyc);
        check("abort_recover_data", data_out[0], PT);
        release_out(0);

        // Async reset mid-round
        send(0, C1_CT, PT);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid[0], 1'b0);
        check("arst_in_ready", in_ready[0], 1'b1);
        check("arst_data_out", data_out[0], 128'h0);
        check("arst_key_idx", key_idx[0], 4'd10);
        @(negedge clk); #2 rst_n = 1'b1;
        send(0, C1_CT, PT);
        wait_valid(0, cyc);
        check("arst_recover_data", data_out[0], PT);
        release_out(0);

        // abort beats in_valid in IDLE
        data_in[0] = C1_CT; cur_pt[0] = PT; in_valid[0] = 1'b1; abort[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0; abort[0] = 1'b0;
        check("idle_abort_in_ready", in_ready[0], 1'b1);
        check("idle_abort_key_idx", key_idx[0], 4'd10);

`ifdef AES_DEC_BYPASS_EN
        bypass[0] = 1'b1;
        send(0, 128'hdeadbeefdeadbeefdeadbeefdeadbeef, 128'hdeadbeefdeadbeefdeadbeefdeadbeef);
        bypass[0] = 1'b0;
        wait_valid(0, cyc);
        check("bypass_latency", cyc, 1);
        check("bypass_data", data_out[0], 128'hdeadbeefdeadbeefdeadbeefdeadbeef);
        release_out(0);
`endif

        // Randomised traffic on both instances
        repeat (600) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                pt2          = {$urandom, $urandom, $urandom, $urandom};
                cur_pt[d]    = pt2;
                data_in[d]   = encrypt(d, pt2);
                in_valid[d]  = 1'($urandom_range(0, 1));
                abort[d]     = ($urandom_range(0, 24) == 0);
                out_ready[d] = ($urandom_range(0, 2) != 0);
            end
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; abort[d] = 1'b0; out_ready[d] = 1'b1;
        end
        repeat (20) @(posedge clk);
        #1;
        check("drain_idle0", in_ready[0], 1'b1);
        check("drain_idle1", in_ready[1], 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
